// File: rtl/banco_registros_pkg.sv
// Shared types and default sizing for the parametrised register file.
package banco_registros_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } estado_t;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_DEPTH   = 8;
  localparam int DEF_RST_VAL = 0;

endpackage

// File: rtl/banco_registros_param_puerto_lectura.sv
// Registered read port: address mux, optional write-to-read forwarding
// (BANCO_REGISTROS_BYPASS_EN), output register and one-cycle valid pulse.
module puerto_lectura
  import banco_registros_pkg::*;
#(
  parameter int               WIDTH   = DEF_WIDTH,
  parameter int               DEPTH   = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int               AW      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] mem [DEPTH],
`ifdef BANCO_REGISTROS_BYPASS_EN
  input  logic             wr_commit,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
`endif
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] data_d, data_q, dato;
  logic             valid_d, valid_q;
  logic             in_range;

  always_comb begin
    in_range = ({1'b0, addr} < DEPTH_L);
    dato     = in_range ? mem[addr] : RST_VAL;
`ifdef BANCO_REGISTROS_BYPASS_EN
    // wr_commit already implies an in-range address
    if (wr_commit && (wr_addr == addr)) dato = wr_data;
`endif
    data_d  = en ? dato : data_q;
    valid_d = en;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/banco_registros_param.sv
// Parametrised register file: one handshaked write port, two registered read
// ports, per-entry written scoreboard and a DEPTH-cycle clear sweep.
// Optional write-to-read forwarding: define BANCO_REGISTROS_BYPASS_EN.
module banco_registros_param
  import banco_registros_pkg::*;
#(
  parameter int               WIDTH   = DEF_WIDTH,
  parameter int               DEPTH   = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DEF_RST_VAL),
  localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd0_en,
  input  logic [AW-1:0]    rd0_addr,
  output logic [WIDTH-1:0] rd0_data,
  output logic             rd0_valid,
  input  logic             rd1_en,
  input  logic [AW-1:0]    rd1_addr,
  output logic [WIDTH-1:0] rd1_data,
  output logic             rd1_valid,
  input  logic             clr_req,
  output logic             busy,
  output logic [DEPTH-1:0] written
);

  localparam logic [AW:0]   DEPTH_L  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH-1);

  estado_t          state_q;
  logic [AW-1:0]    cnt_q;
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] written_d, written_q;
  logic             wr_commit;

  assign wr_ready  = (state_q == IDLE);
  assign busy      = (state_q == CLEAR);
  assign written   = written_q;
  // Out-of-range writes still complete the handshake but touch nothing
  assign wr_commit = wr_valid && wr_ready && ({1'b0, wr_addr} < DEPTH_L);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (clr_req) state_q <= CLEAR;
        end
        CLEAR: begin
          if (cnt_q == LAST_IDX) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_d     = mem_q;
    written_d = written_q;
    if (state_q == CLEAR) begin
      mem_d[cnt_q]     = RST_VAL;
      written_d[cnt_q] = 1'b0;
    end
    if (wr_commit) begin
      mem_d[wr_addr]     = wr_data;
      written_d[wr_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= RST_VAL;
      written_q <= '0;
    end else begin
      mem_q     <= mem_d;
      written_q <= written_d;
    end
  end

  puerto_lectura #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .RST_VAL(RST_VAL), .AW(AW)
  ) u_rd0 (
    .clk       (clk),
    .rst       (rst),
    .en        (rd0_en),
    .addr      (rd0_addr),
    .mem       (mem_q),
`ifdef BANCO_REGISTROS_BYPASS_EN
    .wr_commit (wr_commit),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
`endif
    .data      (rd0_data),
    .valid     (rd0_valid)
  );

  puerto_lectura #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .RST_VAL(RST_VAL), .AW(AW)
  ) u_rd1 (
    .clk       (clk),
    .rst       (rst),
    .en        (rd1_en),
    .addr      (rd1_addr),
    .mem       (mem_q),
`ifdef BANCO_REGISTROS_BYPASS_EN
    .wr_commit (wr_commit),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
`endif
    .data      (rd1_data),
    .valid     (rd1_valid)
  );

endmodule

// File: tb/tb_banco_registros_param.sv
// Bench for banco_registros_param (8x8 default): array model plus directed vectors.
module tb_banco_registros_param;

  localparam int DEPTH = 8;
  localparam logic [7:0] RSTV = 8'h00;

  logic       clk, rst;
  logic       wr_valid, wr_ready;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd0_en, rd0_valid, rd1_en, rd1_valid;
  logic [2:0] rd0_addr, rd1_addr;
  logic [7:0] rd0_data, rd1_data;
  logic       clr_req, busy;
  logic [7:0] written;

  banco_registros_param dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(rd0_data), .rd0_valid(rd0_valid),
    .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(rd1_data), .rd1_valid(rd1_valid),
    .clr_req(clr_req), .busy(busy), .written(written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: plain array of contents, written flags, and the sweep as a pending index
  logic [7:0] m_mem [DEPTH];
  bit   [7:0] m_wr;
  logic [7:0] m_rd0, m_rd1;
  bit         m_v0, m_v1, m_busy;
  int         m_sweep;

  function automatic logic [7:0] model_read(input logic [2:0] a, input bit acc);
    logic [7:0] r;
    r = m_mem[a];
`ifdef BANCO_REGISTROS_BYPASS_EN
    if (acc && wr_addr == a) r = wr_data;
`endif
    return r;
  endfunction

  initial begin
    bit acc;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = RSTV;
        m_wr = '0; m_rd0 = '0; m_rd1 = '0; m_v0 = 0; m_v1 = 0; m_busy = 0; m_sweep = 0;
      end else begin
        acc = wr_valid && !m_busy;
        m_v0 = rd0_en;
        m_v1 = rd1_en;
        if (rd0_en) m_rd0 = model_read(rd0_addr, acc);
        if (rd1_en) m_rd1 = model_read(rd1_addr, acc);
        if (m_busy) begin
          m_mem[m_sweep] = RSTV;
          m_wr[m_sweep]  = 1'b0;
          if (m_sweep == DEPTH-1) m_busy = 0;
          else m_sweep++;
        end else begin
          if (acc) begin
            m_mem[wr_addr] = wr_data;
            m_wr[wr_addr]  = 1'b1;
          end
          if (clr_req) begin
            m_busy  = 1;
            m_sweep = 0;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("rd0_data", rd0_data, m_rd0);
        check("rd0_valid", rd0_valid, m_v0);
        check("rd1_data", rd1_data, m_rd1);
        check("rd1_valid", rd1_valid, m_v1);
        check("written", written, m_wr);
        check("busy", busy, m_busy);
        check("wr_ready", wr_ready, !m_busy);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_valid = 0; wr_addr = 0; wr_data = 0;
    rd0_en = 0; rd0_addr = 0; rd1_en = 0; rd1_addr = 0; clr_req = 0;
  endtask

  task automatic write(input logic [2:0] a, input logic [7:0] d);
    wr_valid = 1; wr_addr = a; wr_data = d;
    tick();
    wr_valid = 0;
  endtask

  initial begin
    int nb, nr;
    idle_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
    chk_en = 1;
    check("rst_wr_ready", wr_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_written", written, 8'h00);
    check("rst_rd0_valid", rd0_valid, 0);

    for (int a = 0; a < DEPTH; a++) begin
      rd0_en = 1; rd0_addr = 3'(a);
      tick();
      check("init_read_data", rd0_data, 8'h00);
      check("init_read_valid", rd0_valid, 1);
      rd0_en = 0;
      tick();
      check("valid_pulse_drop", rd0_valid, 0);
    end

    write(3'd3, 8'hA5);
    rd0_en = 1; rd0_addr = 3'd3; rd1_en = 1; rd1_addr = 3'd3;
    tick();
    idle_inputs();
    check("dual_read_rd0", rd0_data, 8'hA5);
    check("dual_read_rd1", rd1_data, 8'hA5);
    check("written_addr3", written, 8'h08);

    write(3'd5, 8'h11);
    wr_valid = 1; wr_addr = 3'd5; wr_data = 8'h3C;
    rd0_en = 1; rd0_addr = 3'd5;
    tick();
    idle_inputs();
`ifdef BANCO_REGISTROS_BYPASS_EN
    check("raw_same_cycle", rd0_data, 8'h3C);
`else
    check("raw_same_cycle", rd0_data, 8'h11);
`endif
    rd0_en = 1; rd0_addr = 3'd5;
    tick();
    idle_inputs();
    check("raw_next_read", rd0_data, 8'h3C);
    check("rd0_hold_check", rd0_data, 8'h3C);

    for (int a = 0; a < DEPTH; a++) write(3'(a), 8'(a * 17 + 1));
    check("written_full", written, 8'hFF);
    clr_req = 1;
    tick();
    clr_req = 0;
    nb = 0; nr = 0;
    for (int c = 0; c < 12; c++) begin
      if (busy) nb++;
      if (!wr_ready) nr++;
      if (c == 1) begin rd1_en = 1; rd1_addr = 3'd7; end
      if (c == 3) begin wr_valid = 1; wr_addr = 3'd0; wr_data = 8'hEE; end
      if (c == 0) clr_req = 1;
      tick();
      if (c == 1) check("sweep_old_value", rd1_data, 8'h78);
      idle_inputs();
    end
    check("busy_cycles", nb, 8);
    check("not_ready_cycles", nr, 8);
    check("written_after_clear", written, 8'h00);
    for (int a = 0; a < DEPTH; a++) begin
      rd0_en = 1; rd0_addr = 3'(a);
      tick();
      check("cleared_read", rd0_data, RSTV);
    end
    idle_inputs();
    tick();

    wr_valid = 1; wr_addr = 3'd2; wr_data = 8'h5A; clr_req = 1;
    tick();
    idle_inputs();
    check("write_with_clr_busy", busy, 1);
    for (int k = 0; k < 20 && busy; k++) tick();
    check("sweep_done", busy, 0);
    rd1_en = 1; rd1_addr = 3'd2;
    tick();
    idle_inputs();
    check("write_clr_erased", rd1_data, RSTV);
    check("write_clr_written", written, 8'h00);

    write(3'd4, 8'h77);
    clr_req = 1;
    tick();
    clr_req = 0;
    tick();
    rd0_en = 1; rd0_addr = 3'd4;
    tick();
    idle_inputs();
    check("pre_rst_rd0", rd0_data, 8'h77);
    tick();
    check("pre_rst_busy", busy, 1);
    #2 rst = 1;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_wr_ready", wr_ready, 1);
    check("async_rst_written", written, 8'h00);
    check("async_rst_rd0_data", rd0_data, 8'h00);
    check("async_rst_rd0_valid", rd0_valid, 0);
    check("async_rst_rd1_valid", rd1_valid, 0);
    tick();
    rst = 0;
    tick();
    check("post_rst_wr_ready", wr_ready, 1);
    check("post_rst_busy", busy, 0);
    rd0_en = 1; rd0_addr = 3'd4;
    tick();
    idle_inputs();
    check("post_rst_entry", rd0_data, RSTV);
    tick(); tick();

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/banco_registros_param.md
Name: banco_registros_param

Overview:
- Parametrised register file, successor to the fixed 8x8 register block: WIDTH-bit words, DEPTH entries, one handshaked write port, two independent registered read ports.
- Adds a per-entry "written" scoreboard and a multi-cycle hardware clear sweep driven by a small FSM.
- Sits between the datapath control and the functional units as the project's general-purpose storage.

Parameters:
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 8, number of entries (≥2, need not be a power of 2)
- RST_VAL, 0, value loaded into every entry on reset and on clear (WIDTH bits)
- AW (localparam), $clog2(DEPTH), address width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- wr_valid  in  1  write request
- wr_ready  out  1  write port can accept; 1 in IDLE, 0 in CLEAR
- wr_addr  in  AW  write address
- wr_data  in  WIDTH  write data
- rd0_en  in  1  read request, port 0
- rd0_addr  in  AW  read address, port 0
- rd0_data  out  WIDTH  registered read data, port 0
- rd0_valid  out  1  one-cycle pulse: rd0_data updated
- rd1_en, rd1_addr, rd1_data, rd1_valid: same as port 0, independent
- clr_req  in  1  start clear sweep (level sampled in IDLE)
- busy  out  1  1 while in CLEAR
- written  out  DEPTH  bit i = entry i written since last reset/clear

Behaviour:
- Reset (async, any time, including mid-CLEAR): all entries = RST_VAL, written = 0, rdX_data = 0, rdX_valid = 0, state = IDLE, sweep counter = 0. After release: wr_ready = 1, busy = 0.
- FSM states:
  - IDLE: clr_req=1 -> CLEAR with counter = 0.
  - CLEAR: each cycle, entry[counter] <= RST_VAL, written[counter] <= 0, counter++. At counter = DEPTH-1 -> IDLE, so the sweep takes exactly DEPTH cycles. clr_req is ignored while in CLEAR.
- Write:
  - Accepted when wr_valid && wr_ready.
  - entry[wr_addr] <= wr_data and written[wr_addr] <= 1 on the same edge.
  - wr_addr ≥ DEPTH: handshake completes, storage and written unchanged.
- Write and clr_req in the same IDLE cycle: the write is performed; the sweep starts next cycle and erases it.
- Read:
  - Latency 1. rdX_en sampled at edge N -> rdX_data = entry[rdX_addr] and rdX_valid = 1 after edge N.
  - rdX_valid drops the following cycle unless rdX_en is held.
  - rdX_data holds its value when not enabled.
  - rdX_addr ≥ DEPTH: returns RST_VAL with valid = 1.
  - Reads are served in both IDLE and CLEAR and return current contents; entries not yet swept return their old value.
- Both ports reading the same address: both return the same data.
- Read and write to the same address in the same cycle (no bypass): the read returns the old value.

Optional Feature:
- Macro: BANCO_REGISTROS_BYPASS_EN
- Defined: a same-cycle accepted write to the read address forwards wr_data to rdX_data (write-before-read), on each port independently.
- Undefined: the read returns the pre-write value.

Decomposition:
- Package banco_registros_pkg: FSM state enum {IDLE, CLEAR}, default WIDTH/DEPTH constants, RST_VAL default.
- One natural sub-module, puerto_lectura: address mux + optional bypass + output register + valid pulse. Instantiated twice.

Test Plan:
- Reset then read all 8 addresses on rd0 -> each returns 0x00 one cycle after rd0_en, rd0_valid pulsed, written = 8'h00.
- Write 0xA5 to addr 3, then read addr 3 on rd0 and addr 3 on rd1 simultaneously -> both 0xA5 next cycle, written = 8'h08.
- Same-cycle write 0x3C to addr 5 and rd0 read of addr 5 (old value 0x11):
  - without the macro -> rd0_data = 0x11
  - with BANCO_REGISTROS_BYPASS_EN -> 0x3C
- Fill all entries, pulse clr_req:
  - busy = 1 and wr_ready = 0 for exactly 8 cycles
  - a read of addr 7 during cycle 2 returns the old value
  - after the sweep, all reads return RST_VAL and written = 0
- Write attempt with wr_valid = 1 during CLEAR -> not accepted, contents unaffected; write plus clr_req in the same IDLE cycle -> entry ends at RST_VAL.
- Assert rst mid-sweep (cycle 4) -> all outputs at reset values immediately (async); after release state = IDLE, wr_ready = 1.
